// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/writeback sequencer between decode and a combinational ALU.
//   Accepts one decoded op at a time, drives the registered ALU inputs
//   (alu_a/alu_b/alufn), waits a fixed settle time (MUL_CYCLES for MUL,
//   ALU_CYCLES otherwise), captures the ALU result and flags, and offers
//   them to writeback. Illegal ops bypass the ALU and return wb_err=1.
//   Saturating counters track completed ops and completed ops with overflow.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               op handshake; in_op/in_a/in_b/in_rd payload
//   alu_a/alu_b/alufn               registered ALU inputs
//   alu_otp/alu_zero/alu_overflow   ALU result and flags
//   wb_valid/wb_ready               result handshake
//   wb_data/wb_rd/wb_zero/wb_overflow/wb_err   result payload
//   op_count/ovf_count              saturating statistics
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// EXEC  | ALU inputs held, counting down the settle time
// WB    | result presented, waiting for wb_ready

module alu_issue_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int ALU_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [4:0]       in_rd,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [5:0]       alufn,
    input  logic [31:0]      alu_otp,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [4:0]       wb_rd,
    output logic             wb_zero,
    output logic             wb_overflow,
    output logic             wb_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam int MAX_CYC = (MUL_CYCLES > ALU_CYCLES) ? MUL_CYCLES : ALU_CYCLES;
    localparam int WAIT_W  = $clog2(MAX_CYC + 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [5:0]         alufn_q, alufn_d;
    logic               wb_valid_q, wb_valid_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic               wb_zero_q, wb_zero_d;
    logic               wb_ovf_q, wb_ovf_d;
    logic               wb_err_q, wb_err_d;
    logic [CNT_W-1:0]   op_cnt_q, op_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic [5:0]         fn;

    always_comb begin
        case (in_op)
            4'd0:    fn = 6'b000000;
            4'd1:    fn = 6'b000001;
            4'd2:    fn = 6'b000010;
            4'd3:    fn = 6'b000100;
            4'd4:    fn = 6'b000101;
            4'd5:    fn = 6'b000110;
            4'd6:    fn = 6'b001000;
            4'd7:    fn = 6'b001001;
            default: fn = 6'b111111;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alufn_d    = alufn_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_zero_d  = wb_zero_q;
        wb_ovf_d   = wb_ovf_q;
        wb_err_d   = wb_err_q;
        op_cnt_d   = op_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alufn_d = fn;
                    alu_a_d = in_a;
                    // shifts only use the low 5 bits of the shift amount
                    alu_b_d = (in_op == 4'd6 || in_op == 4'd7) ? {27'b0, in_b[4:0]} : in_b;
                    wb_rd_d = in_rd;
                    if (in_op[3]) begin
                        state_d    = WB;
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        wb_data_d  = 32'd0;
                        wb_zero_d  = 1'b0;
                        wb_ovf_d   = 1'b0;
                    end else begin
                        state_d = EXEC;
                        wait_d  = (in_op == 4'd2) ? WAIT_W'(MUL_CYCLES) : WAIT_W'(ALU_CYCLES);
                    end
                end
            end
            EXEC: begin
                if (wait_q == WAIT_W'(1)) begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b0;
                    wb_data_d  = alu_otp;
                    wb_zero_d  = alu_zero;
                    wb_ovf_d   = alu_overflow;
                end
                wait_d = wait_q - WAIT_W'(1);
            end
            WB: begin
                if (wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                    if (op_cnt_q != '1)
                        op_cnt_d = op_cnt_q + CNT_W'(1);
                    if (wb_ovf_q && ovf_cnt_q != '1)
                        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alufn_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_zero_q  <= 1'b0;
            wb_ovf_q   <= 1'b0;
            wb_err_q   <= 1'b0;
            op_cnt_q   <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alufn_q    <= alufn_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_zero_q  <= wb_zero_d;
            wb_ovf_q   <= wb_ovf_d;
            wb_err_q   <= wb_err_d;
            op_cnt_q   <= op_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // gated with rst_n so in_ready is low for the whole reset, not just after it
    assign in_ready    = rst_n & (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alufn       = alufn_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_zero     = wb_zero_q;
    assign wb_overflow = wb_ovf_q;
    assign wb_err      = wb_err_q;
    assign op_count    = op_cnt_q;
    assign ovf_count   = ovf_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int MULC = 2;
    localparam int ALUC = 1;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_rd;
    logic [31:0] alu_a, alu_b, alu_otp;
    logic [5:0]  alufn;
    logic        alu_zero, alu_overflow;
    logic        wb_valid, wb_ready, wb_zero, wb_overflow, wb_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [15:0] op_count, ovf_count;

    // second instance with narrow counters for the saturation check
    logic        s_in_ready, s_wb_valid, s_wb_zero, s_wb_ovf, s_wb_err;
    logic [31:0] s_alu_a, s_alu_b, s_wb_data;
    logic [5:0]  s_alufn;
    logic [4:0]  s_wb_rd;
    logic [3:0]  s_op_count, s_ovf_count;

    logic        ovf_force;

    alu_issue_ctrl #(.MUL_CYCLES(MULC), .ALU_CYCLES(ALUC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alufn(alufn),
        .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_zero(wb_zero), .wb_overflow(wb_overflow), .wb_err(wb_err),
        .op_count(op_count), .ovf_count(ovf_count));

    alu_issue_ctrl #(.MUL_CYCLES(MULC), .ALU_CYCLES(ALUC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alufn(s_alufn),
        .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .wb_valid(s_wb_valid), .wb_ready(wb_ready), .wb_data(s_wb_data), .wb_rd(s_wb_rd),
        .wb_zero(s_wb_zero), .wb_overflow(s_wb_ovf), .wb_err(s_wb_err),
        .op_count(s_op_count), .ovf_count(s_ovf_count));

    // ALU stub driven by the main DUT's registered inputs
    always_comb begin
        alu_otp      = 32'd0;
        alu_overflow = ovf_force;
        case (alufn)
            6'b000000: begin
                alu_otp = alu_a + alu_b;
                alu_overflow = ovf_force | ((alu_a[31] == alu_b[31]) && (alu_otp[31] != alu_a[31]));
            end
            6'b000001: begin
                alu_otp = alu_a - alu_b;
                alu_overflow = ovf_force | ((alu_a[31] != alu_b[31]) && (alu_otp[31] != alu_a[31]));
            end
            6'b000010: alu_otp = alu_a * alu_b;
            6'b000100: alu_otp = alu_a & alu_b;
            6'b000101: alu_otp = alu_a | alu_b;
            6'b000110: alu_otp = alu_a ^ alu_b;
            6'b001000: alu_otp = alu_a << alu_b[4:0];
            6'b001001: alu_otp = alu_a >> alu_b[4:0];
            default:   alu_otp = 32'd0;
        endcase
        alu_zero = (alu_otp == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return p[31:0];
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return a << (b % 32);
            4'd7: return a >> (b % 32);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic f);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op > 4'd7) return 1'b0;
        s = (op == 4'd0) ? sa + sb : sa - sb;
        if ((op == 4'd0 || op == 4'd1) && (s > 64'sd2147483647 || s < -64'sd2147483648)) return 1'b1;
        return f;
    endfunction

    function automatic logic [5:0] m_fn(input logic [3:0] op);
        logic [5:0] tbl [0:7];
        tbl = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};
        return (op > 4'd7) ? 6'b111111 : tbl[op[2:0]];
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    longint      cyc = 0;
    logic        m_pending;
    longint      m_vfrom;
    logic [31:0] m_data, m_a, m_b;
    logic [5:0]  m_fnl;
    logic [4:0]  m_rd;
    logic        m_zero, m_ovfv, m_err;
    longint      m_ops, m_ovfs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_a <= '0; m_b <= '0; m_fnl <= '0;
            m_ops <= 0; m_ovfs <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_pending) begin
                if (cyc + 1 > m_vfrom && wb_ready) begin
                    m_pending <= 1'b0;
                    m_ops <= m_ops + 1;
                    if (m_ovfv) m_ovfs <= m_ovfs + 1;
                end
            end else if (in_valid) begin
                m_pending <= 1'b1;
                m_vfrom   <= cyc + 1 + ((in_op > 4'd7) ? 0 : (in_op == 4'd2) ? MULC : ALUC);
                m_a       <= in_a;
                m_b       <= (in_op == 4'd6 || in_op == 4'd7) ? (in_b % 32) : in_b;
                m_fnl     <= m_fn(in_op);
                m_rd      <= in_rd;
                m_data    <= m_result(in_op, in_a, in_b);
                m_zero    <= (in_op <= 4'd7) && (m_result(in_op, in_a, in_b) == 32'd0);
                m_ovfv    <= m_ovf(in_op, in_a, in_b, ovf_force);
                m_err     <= (in_op > 4'd7);
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        logic ev;
        ev = rst_n && m_pending && (cyc >= m_vfrom);
        chk("in_ready", in_ready, rst_n && !m_pending);
        chk("wb_valid", wb_valid, ev);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alufn", alufn, m_fnl);
        chk("op_count", op_count, sat(m_ops, 16));
        chk("ovf_count", ovf_count, sat(m_ovfs, 16));
        chk("op_count4", s_op_count, sat(m_ops, 4));
        chk("ovf_count4", s_ovf_count, sat(m_ovfs, 4));
        if (ev) begin
            chk("wb_data", wb_data, m_data);
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_zero", wb_zero, m_zero);
            chk("wb_overflow", wb_overflow, m_ovfv);
            chk("wb_err", wb_err, m_err);
        end
    end

    // ---------------- directed helpers ----------------
    int          r_lat;
    logic [31:0] r_data;
    logic        r_zero, r_err;
    logic [4:0]  r_rd;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bit got;
        @(negedge clk); #1;
        chk("idle_before_op", in_ready, 1'b1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
        step();
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = 4'($urandom_range(15, 0));
        got = 0; r_lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (i > 1) step();
            if (wb_valid) begin
                got = 1; r_lat = i;
            end
        end
        if (!got) chk("wb_valid_timeout", 1'b0, 1'b1);
        r_data = wb_data; r_zero = wb_zero; r_err = wb_err; r_rd = wb_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hold;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0; in_rd = '0;
        wb_ready = 1'b1; ovf_force = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_alufn", alufn, 6'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1'b1);

        do_op(4'd0, 32'd5, 32'd7, 5'd3);
        chk("add_lat", r_lat, 2);
        chk("add_data", r_data, 12);
        chk("add_rd", r_rd, 3);
        chk("add_zero", r_zero, 0);
        step();
        chk("add_op_count", op_count, 1);

        do_op(4'd2, 32'h10000, 32'h10000, 5'd9);
        chk("mul_lat", r_lat, 3);
        chk("mul_alufn", alufn, 6'b000010);
        chk("mul_data", r_data, 0);
        chk("mul_zero", r_zero, 1);
        step();

        do_op(4'd6, 32'd1, 32'h23, 5'd1);
        chk("sll_alu_b", alu_b, 3);
        chk("sll_alufn", alufn, 6'b001000);
        chk("sll_data", r_data, 8);
        step();

        do_op(4'd7, 32'h80000000, 32'd31, 5'd2);
        chk("srl_data", r_data, 1);
        step();

        do_op(4'd12, 32'd55, 32'd66, 5'd4);
        chk("ill_lat", r_lat, 1);
        chk("ill_err", r_err, 1);
        chk("ill_data", r_data, 0);
        chk("ill_alufn", alufn, 6'b111111);
        step();
        chk("ill_op_count", op_count, 5);

        // stall with forced overflow
        wb_ready = 1'b0; ovf_force = 1'b1;
        do_op(4'd0, 32'd1, 32'd1, 5'd7);
        hold = wb_data;
        chk("stall_data", hold, 2);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); in_op = 4'd1;
            step();
            chk("stall_valid", wb_valid, 1);
            chk("stall_ready", in_ready, 0);
            chk("stall_hold", wb_data, hold);
        end
        in_valid = 1'b0; wb_ready = 1'b1;
        step();
        ovf_force = 1'b0;
        chk("stall_op_count", op_count, 6);
        chk("stall_ovf_count", ovf_count, 1);
        chk("stall_released", wb_valid, 0);

        // reset during EXEC
        @(negedge clk); #1;
        in_valid = 1'b1; in_op = 4'd2; in_a = 32'd3; in_b = 32'd4; in_rd = 5'd5;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", wb_valid, 0);
        chk("rst_exec_ready", in_ready, 0);
        chk("rst_exec_alufn", alufn, 0);
        chk("rst_exec_alu_a", alu_a, 0);
        chk("rst_exec_opcnt", op_count, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_wb", wb_valid, 0);
        end
        do_op(4'd0, 32'd2, 32'd3, 5'd6);
        chk("after_rst_data", r_data, 5);
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            in_valid = ($urandom_range(1, 0) == 1);
            in_op    = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 8)) : 4'($urandom_range(7, 0));
            in_a     = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
            in_b     = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
            in_rd    = 5'($urandom_range(31, 0));
            wb_ready = ($urandom_range(2, 0) != 0);
            if (!m_pending) ovf_force = ($urandom_range(3, 0) == 0);
        end
        @(negedge clk); #1;
        in_valid = 1'b0; wb_ready = 1'b1;
        repeat (5) step();
        ovf_force = 1'b0;

        // saturation on the narrow-counter instance
        @(negedge clk); #1 rst_n = 1'b0;
        step();
        @(negedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            do_op(4'd9, 32'd0, 32'd0, 5'd0);
            step();
        end
        chk("sat_op_count4", s_op_count, 15);
        chk("sat_op_count16", op_count, 19);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
